// File: rtl/calc_operand_entry_if.sv
// Handshake and data bundle between the keypad/top FSM (master) and one operand
// entry block (slave). The value width follows NDIGITS.
interface calc_operand_entry_if #(
  parameter int NDIGITS = 4
);
  localparam int CW = $clog2(NDIGITS + 1);

  logic                   enable;
  logic                   key_valid;
  logic [3:0]             key_code;
  logic [4*NDIGITS-1:0]   value;
  logic [CW-1:0]          digit_count;
  logic                   digit_strobe;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  modport master (
    output enable, key_valid, key_code,
    input  value, digit_count, digit_strobe, busy, done, overflow
  );

  modport slave (
    input  enable, key_valid, key_code,
    output value, digit_count, digit_strobe, busy, done, overflow
  );
endinterface

// File: rtl/calc_operand_entry.sv
// BCD operand entry: edge-detects keypad strobes and shifts digits into a register,
// with backspace, clear, enter and optional auto-commit when the buffer fills.
module calc_operand_entry #(
  parameter int NDIGITS     = 4,
  parameter bit AUTO_COMMIT = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  calc_operand_entry_if.slave bus
);
  localparam int VW = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0] FULL      = CW'(NDIGITS);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [3:0]    KEY_BACK  = 4'hB;
  localparam logic [3:0]    KEY_CLEAR = 4'hC;
  localparam logic [3:0]    KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;

  state_t          state, state_next;
  logic            key_prev;
  logic            key_event;
  logic [VW-1:0]   value_q, value_next;
  logic [CW-1:0]   count_q, count_next;
  logic            strobe_q, strobe_next;
  logic            busy_q, busy_next;
  logic            done_q, done_next;
  logic            ovf_q, ovf_next;

  assign key_event = bus.key_valid & ~key_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      key_prev <= 1'b0;
      value_q  <= '0;
      count_q  <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_next;
      key_prev <= bus.key_valid;
      value_q  <= value_next;
      count_q  <= count_next;
      strobe_q <= strobe_next;
      busy_q   <= busy_next;
      done_q   <= done_next;
      ovf_q    <= ovf_next;
    end
  end

  // Key events only matter in ENTRY; losing enable there aborts ahead of any key.
  always_comb begin
    state_next  = state;
    value_next  = value_q;
    count_next  = count_q;
    strobe_next = 1'b0;
    ovf_next    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable) begin
          state_next = ENTRY;
          value_next = '0;
          count_next = '0;
        end
      end
      ENTRY: begin
        if (!bus.enable) begin
          state_next = IDLE;
          value_next = '0;
          count_next = '0;
        end else if (key_event) begin
          if (bus.key_code <= 4'd9) begin
            if (count_q < FULL) begin
              value_next  = {value_q[VW-5:0], bus.key_code};
              count_next  = count_q + ONE;
              strobe_next = 1'b1;
              if (AUTO_COMMIT && (count_q == FULL - ONE)) begin
                state_next = COMMIT;
              end
            end else if (!AUTO_COMMIT) begin
              ovf_next = 1'b1;
            end
          end else begin
            case (bus.key_code)
              KEY_BACK: begin
                if (count_q != '0) begin
                  value_next = value_q >> 4;
                  count_next = count_q - ONE;
                end
              end
              KEY_CLEAR: begin
                value_next = '0;
                count_next = '0;
              end
              KEY_ENTER: state_next = COMMIT;
              default: ;
            endcase
          end
        end
      end
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == ENTRY);
    done_next = (state_next == COMMIT);
  end

  assign bus.value        = value_q;
  assign bus.digit_count  = count_q;
  assign bus.digit_strobe = strobe_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed bench for calc_operand_entry in three configurations; committed operands
// are queued as expectations and checked when each done pulse appears.
module tb_calc_operand_entry;
  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] en;
  int         sel;

  always #5 clk = ~clk;

  calc_operand_entry_if #(.NDIGITS(4)) bus_a4 ();
  calc_operand_entry_if #(.NDIGITS(4)) bus_m4 ();
  calc_operand_entry_if #(.NDIGITS(6)) bus_a6 ();

  assign bus_a4.enable    = en[0];
  assign bus_m4.enable    = en[1];
  assign bus_a6.enable    = en[2];
  assign bus_a4.key_valid = key_valid;
  assign bus_m4.key_valid = key_valid;
  assign bus_a6.key_valid = key_valid;
  assign bus_a4.key_code  = key_code;
  assign bus_m4.key_code  = key_code;
  assign bus_a6.key_code  = key_code;

  calc_operand_entry #(.NDIGITS(4), .AUTO_COMMIT(1'b1)) dut_a4 (.clk(clk), .reset(reset), .bus(bus_a4));
  calc_operand_entry #(.NDIGITS(4), .AUTO_COMMIT(1'b0)) dut_m4 (.clk(clk), .reset(reset), .bus(bus_m4));
  calc_operand_entry #(.NDIGITS(6), .AUTO_COMMIT(1'b1)) dut_a6 (.clk(clk), .reset(reset), .bus(bus_a6));

  logic [23:0] obs_value;
  logic [2:0]  obs_count;
  logic        obs_strobe, obs_busy, obs_done, obs_ovf;

  always_comb begin
    obs_value  = 24'(bus_a6.value);
    obs_count  = bus_a6.digit_count;
    obs_strobe = bus_a6.digit_strobe;
    obs_busy   = bus_a6.busy;
    obs_done   = bus_a6.done;
    obs_ovf    = bus_a6.overflow;
    case (sel)
      0: begin
        obs_value  = 24'(bus_a4.value);
        obs_count  = bus_a4.digit_count;
        obs_strobe = bus_a4.digit_strobe;
        obs_busy   = bus_a4.busy;
        obs_done   = bus_a4.done;
        obs_ovf    = bus_a4.overflow;
      end
      1: begin
        obs_value  = 24'(bus_m4.value);
        obs_count  = bus_m4.digit_count;
        obs_strobe = bus_m4.digit_strobe;
        obs_busy   = bus_m4.busy;
        obs_done   = bus_m4.done;
        obs_ovf    = bus_m4.overflow;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [23:0] value;
    logic [2:0]  count;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  int   ovf_cnt = 0;
  int   done_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input logic [23:0] v, input logic [2:0] c);
    exp_t e;
    e.value = v;
    e.count = c;
    sb.push_back(e);
  endtask

  // One clock; outputs of the selected DUT are sampled on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (obs_strobe) strobe_cnt++;
    if (obs_ovf) ovf_cnt++;
    if (obs_done) begin
      done_cnt++;
      checkOutput("busy_low_at_done", 32'(obs_busy), 32'd0);
      checkOutput("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("commit_value", 32'(obs_value), 32'(e.value));
        checkOutput("commit_count", 32'(obs_count), 32'(e.count));
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code, input int hold);
    key_code  = code;
    key_valid = 1'b1;
    repeat (hold) tick();
    key_valid = 1'b0;
    tick();
  endtask

  task automatic waitDone(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(done_cnt - start), 32'd1);
  endtask

  initial begin
    int dsave;
    reset = 1'b1; en = 3'b000; key_valid = 1'b0; key_code = 4'h0; sel = 0;
    repeat (2) tick();
    checkOutput("reset_value", 32'(obs_value), 32'd0);
    checkOutput("reset_count", 32'(obs_count), 32'd0);
    checkOutput("reset_busy", 32'(obs_busy), 32'd0);
    checkOutput("reset_done", 32'(obs_done), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] auto-commit 4 digits");
    en[0] = 1'b1;
    tick();
    checkOutput("entry_busy", 32'(obs_busy), 32'd1);
    strobe_cnt = 0;
    pushExpect(24'h001234, 3'd4);
    applyStimulus(4'h1, 1);
    applyStimulus(4'h2, 1);
    applyStimulus(4'h3, 1);
    key_code = 4'h4; key_valid = 1'b1;
    tick();
    checkOutput("last_strobe", 32'(obs_strobe), 32'd1);
    checkOutput("auto_done_with_strobe", 32'(obs_done), 32'd1);
    key_valid = 1'b0; en[0] = 1'b0;
    tick();
    checkOutput("strobe_count_4", 32'(strobe_cnt), 32'd4);
    checkOutput("idle_busy", 32'(obs_busy), 32'd0);
    checkOutput("held_value_1234", 32'(obs_value), 32'h1234);
    checkOutput("held_count_4", 32'(obs_count), 32'd4);
    checkOutput("no_overflow_auto", 32'(ovf_cnt), 32'd0);

    $display("[TB] backspace and enter");
    en[0] = 1'b1;
    tick();
    pushExpect(24'h000079, 3'd2);
    applyStimulus(4'h7, 1);
    applyStimulus(4'h8, 1);
    applyStimulus(4'hB, 1);
    applyStimulus(4'h9, 1);
    checkOutput("pre_enter_value", 32'(obs_value), 32'h0079);
    key_code = 4'hE; key_valid = 1'b1;
    waitDone("enter_done", 3);
    key_valid = 1'b0; en[0] = 1'b0;
    tick();
    checkOutput("held_value_0079", 32'(obs_value), 32'h0079);

    $display("[TB] held key counts once");
    en[0] = 1'b1;
    tick();
    strobe_cnt = 0;
    applyStimulus(4'h5, 5);
    checkOutput("held_key_strobes", 32'(strobe_cnt), 32'd1);
    checkOutput("held_key_count", 32'(obs_count), 32'd1);
    checkOutput("held_key_value", 32'(obs_value), 32'h0005);
    en[0] = 1'b0;
    tick();

    $display("[TB] overflow without auto-commit");
    sel = 1; en[1] = 1'b1;
    tick();
    ovf_cnt = 0;
    pushExpect(24'h009999, 3'd4);
    repeat (4) applyStimulus(4'h9, 1);
    applyStimulus(4'h1, 1);
    checkOutput("overflow_pulses", 32'(ovf_cnt), 32'd1);
    checkOutput("overflow_value", 32'(obs_value), 32'h9999);
    checkOutput("overflow_count", 32'(obs_count), 32'd4);
    checkOutput("overflow_busy", 32'(obs_busy), 32'd1);
    key_code = 4'hE; key_valid = 1'b1;
    waitDone("overflow_enter_done", 3);
    key_valid = 1'b0; en[1] = 1'b0;
    tick();

    $display("[TB] clear, empty enter, ignored codes");
    en[1] = 1'b1;
    tick();
    pushExpect(24'h0, 3'd0);
    applyStimulus(4'h3, 1);
    applyStimulus(4'hC, 1);
    checkOutput("clear_count", 32'(obs_count), 32'd0);
    key_code = 4'hE; key_valid = 1'b1;
    waitDone("clear_enter_done", 3);
    key_valid = 1'b0; en[1] = 1'b0;
    tick();
    en[1] = 1'b1;
    tick();
    pushExpect(24'h0, 3'd0);
    key_code = 4'hE; key_valid = 1'b1;
    waitDone("empty_enter_done", 3);
    key_valid = 1'b0; en[1] = 1'b0;
    tick();
    en[1] = 1'b1;
    tick();
    strobe_cnt = 0;
    applyStimulus(4'h2, 1);
    applyStimulus(4'hA, 1);
    applyStimulus(4'hD, 1);
    applyStimulus(4'hF, 1);
    checkOutput("ignored_value", 32'(obs_value), 32'h0002);
    checkOutput("ignored_count", 32'(obs_count), 32'd1);
    checkOutput("ignored_strobes", 32'(strobe_cnt), 32'd1);
    pushExpect(24'h000002, 3'd1);
    key_code = 4'hE; key_valid = 1'b1;
    waitDone("ignored_enter_done", 3);
    key_valid = 1'b0; en[1] = 1'b0;
    tick();

    $display("[TB] abort and reset mid-entry");
    sel = 0; en[0] = 1'b1;
    tick();
    applyStimulus(4'h4, 1);
    applyStimulus(4'h2, 1);
    checkOutput("pre_abort_value", 32'(obs_value), 32'h0042);
    dsave = done_cnt;
    en[0] = 1'b0;
    tick();
    checkOutput("abort_value", 32'(obs_value), 32'd0);
    checkOutput("abort_count", 32'(obs_count), 32'd0);
    checkOutput("abort_busy", 32'(obs_busy), 32'd0);
    tick();
    checkOutput("abort_no_done", 32'(done_cnt - dsave), 32'd0);
    en[0] = 1'b1;
    tick();
    applyStimulus(4'h5, 1);
    applyStimulus(4'h6, 1);
    key_code = 4'h7; key_valid = 1'b1; reset = 1'b1;
    tick();
    checkOutput("midreset_value", 32'(obs_value), 32'd0);
    checkOutput("midreset_count", 32'(obs_count), 32'd0);
    checkOutput("midreset_busy", 32'(obs_busy), 32'd0);
    checkOutput("midreset_strobe", 32'(obs_strobe), 32'd0);
    reset = 1'b0; key_valid = 1'b0; en[0] = 1'b0;
    tick();

    $display("[TB] six-digit auto-commit");
    sel = 2;
    key_code = 4'h7; key_valid = 1'b1; en[2] = 1'b1;
    tick();
    key_valid = 1'b0;
    strobe_cnt = 0;
    tick();
    checkOutput("idle_event_count", 32'(obs_count), 32'd0);
    checkOutput("idle_event_strobes", 32'(strobe_cnt), 32'd0);
    checkOutput("idle_event_busy", 32'(obs_busy), 32'd1);
    pushExpect(24'h123456, 3'd6);
    for (int d = 1; d <= 5; d++) applyStimulus(4'(d), 1);
    key_code = 4'h6; key_valid = 1'b1;
    tick();
    checkOutput("six_last_strobe", 32'(obs_strobe), 32'd1);
    checkOutput("six_done", 32'(obs_done), 32'd1);
    key_valid = 1'b0; en[2] = 1'b0;
    tick();
    checkOutput("six_held_value", 32'(obs_value), 32'h123456);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
